// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer: WIDTH-bit add/subtract built by time-sharing one
// 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (ready only in IDLE)
//   in0, in1, carry_in, sub operands; sub=1 computes in0 - in1 - carry_in
//   out_valid/out_ready     result handshake (valid only in DONE)
//   sum, carry_out,overflow registered result; carry_out=1 means no borrow on sub
//   busy                    high in RUN or DONE

module carry_lookahead_adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Flattened lookahead equations; no ripple between bit positions.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_multiword_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              c_reg, co_reg, ov_reg;
  logic [3:0]        a_nib, b_nib, s_nib;
  logic              c4, last;

  assign a_nib = a_reg[idx*4 +: 4];
  assign b_nib = b_reg[idx*4 +: 4];
  assign last  = (idx == IDXW'(NIBBLES - 1));

  carry_lookahead_adder_4bits u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c_reg),
    .s    (s_nib),
    .cout (c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtract is A + ~B + ~borrow_in, so operand B and the incoming carry are
  // inverted once at accept time and the slice only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      idx     <= '0;
      c_reg   <= 1'b0;
      co_reg  <= 1'b0;
      ov_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= in0;
          b_reg <= sub ? ~in1 : in1;
          c_reg <= sub ^ carry_in;
          idx   <= '0;
        end
        RUN: begin
          sum_reg[idx*4 +: 4] <= s_nib;
          c_reg               <= c4;
          if (last) begin
            co_reg <= c4;
            // carry into bit 3 recovered from the slice's bit-3 sum
            ov_reg <= c4 ^ (a_nib[3] ^ b_nib[3] ^ s_nib[3]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_reg;
  assign carry_out = co_reg;
  assign overflow  = ov_reg;
endmodule

// File: doc/cla_multiword_sequencer.md
# cla_multiword_sequencer

Multi-cycle wide adder/subtractor controller that time-shares a single 4-bit carry-lookahead slice (`carry_lookahead_adder_4bits`) across a WIDTH-bit operand pair. It processes one nibble per cycle, least-significant first, and registers the inter-nibble carry. It accepts operands over a valid/ready handshake, holds the result until the consumer takes it, and sits between operand producers (e.g. FP mantissa alignment) and any wide-add consumer where area matters more than latency.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and ≥ 4. Derived constant `NIBBLES` = WIDTH/4.
- `clk`  input  1: rising-edge clock, single clock domain.
- `rst_n`  input  1: asynchronous active-low reset.
- `in_valid`  input  1: operands present.
- `in_ready`  output  1: block can accept operands. High only in IDLE.
- `in0`  input  WIDTH: operand A.
- `in1`  input  WIDTH: operand B.
- `carry_in`  input  1: carry-in for add; borrow-in for subtract.
- `sub`  input  1: 0 = A+B+carry_in; 1 = A−B−carry_in.
- `out_valid`  output  1: result valid. High only in DONE.
- `out_ready`  input  1: consumer accepts result.
- `sum`  output  WIDTH: registered result.
- `carry_out`  output  1: raw carry out of the MSB nibble. In subtract mode 1 = no borrow.
- `overflow`  output  1: two's-complement signed overflow of the full-width operation.
- `busy`  output  1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Nibble index counter `idx` has width ceil(log2(NIBBLES)), minimum 1 bit.
- **IDLE**
  - On `in_valid & in_ready`: latch `a_reg` = in0 and `b_reg` = sub ? ~in1 : in1.
  - Set `c_reg` = sub ? ~carry_in : carry_in, set `idx` = 0, and go to RUN.
  - Inputs are sampled only on this handshake edge.
- **RUN**, each cycle:
  - Drive the slice with a_reg[4*idx+:4], b_reg[4*idx+:4] and c_reg.
  - Write the slice sum into sum_reg[4*idx+:4] and set `c_reg` to the slice carry_out.
  - When idx == NIBBLES−1:
    - `carry_out` takes the slice carry_out.
    - `overflow` = c4 ^ c3 of this last nibble, where c3 = the carry into bit 3 = a[3]^b[3]^s[3] of the last nibble.
    - Go to DONE.
  - Otherwise increment idx.
- **DONE**
  - `out_valid` = 1; `sum`, `carry_out` and `overflow` are held stable.
  - On `out_ready`, go to IDLE. The result registers keep their values until the next RUN overwrites them.
- `in_valid` outside IDLE is ignored and does not block or corrupt the operation.
- With NIBBLES = 1, RUN lasts exactly one cycle.
- `sum` is driven from sum_reg throughout. Only nibbles not yet written may show stale data during RUN; consumers must qualify `sum` with `out_valid`.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE, idx = 0, c_reg = 0, sum_reg = 0, carry_out = 0, overflow = 0.
  - Hence in_ready = 1, out_valid = 0, busy = 0.
- `in_ready`, `out_valid` and `busy` are decoded combinationally from the state register. There is no combinational path from in_valid or out_ready to any output.
- Latency: with accept at clock edge E, `out_valid` rises after edge E+NIBBLES (4 cycles for WIDTH=16).
- Minimum issue interval: NIBBLES+2 cycles with out_ready tied high (accept, NIBBLES×RUN, DONE, back in IDLE).
- Backpressure: DONE persists indefinitely while out_ready = 0, with all outputs frozen.
- Reset mid-RUN or mid-DONE: the in-flight operation is discarded and no out_valid is produced. The first operation after reset release is computed correctly.
- Combinational critical path per cycle: one 4-bit CLA slice plus the nibble mux.

## Test plan
- Add, WIDTH=16: in0=0x1234, in1=0x0FCD, carry_in=1, sub=0 → sum=0x2202, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Carry ripple across all nibbles: 0xFFFF + 0x0001, cin=0 → sum=0x0000, carry_out=1, overflow=0. Then 0x7FFF + 0x0001 → sum=0x8000, carry_out=0, overflow=1.
- Subtract: 0x0005 − 0x0007, carry_in=0, sub=1 → sum=0xFFFE, carry_out=0, overflow=0. Then 0x8000 − 0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands → sum is stable, in_ready=0, and the new operands are not taken. Release out_ready → IDLE next cycle, then accept proceeds.
- Reset mid-operation: assert rst_n=0 while idx=2 → all outputs return to reset values immediately and out_valid is never seen. Next op 0x00FF + 0x0001 → 0x0100.
- Random back-to-back ops with WIDTH=4 and WIDTH=32, compared against a reference model of A±B±cin, checking sum, carry_out, overflow and the NIBBLES-cycle latency on each.
